// File: rtl/uart_pkg.sv
// Shared UART definitions for the multi-byte transmitter and receiver.
// Holds the frame header bytes, the baud divider helper and the frame FSM states.
package uart_pkg;

  localparam logic [7:0] HDR0 = 8'h55;
  localparam logic [7:0] HDR1 = 8'hAA;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR0 = 3'd1,
    S_HDR1 = 3'd2,
    S_PAY  = 3'd3,
    S_CHK  = 3'd4,
    S_DONE = 3'd5
  } frame_state_e;

  // Cycles per bit; integer division truncates towards zero.
  function automatic int unsigned bps_cnt(input int unsigned clk, input int unsigned bps);
    return clk / bps;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 serialiser. Owns the baud and bit counters.
// byte_ready is high while idle and during the last cycle of a stop bit, so the
// parent can chain bytes back-to-back without an idle gap on the line.
module uart_byte_tx #(
  parameter int unsigned BPS_CNT = 434
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       byte_start,
  input  logic [7:0] byte_data,
  output logic       txd,
  output logic       byte_ready
);

  localparam int unsigned CW = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BPS_CNT - 1);

  logic          active_q, active_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [8:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          last_s;

  assign last_s     = active_q && (bit_idx_q == 4'd9) && (baud_q == BAUD_LAST);
  assign byte_ready = !active_q || last_s;
  assign txd        = txd_q;

  // Next-state logic: load a byte, advance the baud/bit counters, or idle high.
  always_comb begin
    active_d  = active_q;
    bit_idx_d = bit_idx_q;
    baud_d    = baud_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    if (byte_start && byte_ready) begin
      active_d  = 1'b1;
      bit_idx_d = 4'd0;
      baud_d    = '0;
      shift_d   = {1'b1, byte_data};
      txd_d     = 1'b0;
    end else if (active_q) begin
      if (baud_q == BAUD_LAST) begin
        baud_d = '0;
        if (bit_idx_q == 4'd9) begin
          active_d = 1'b0;
          txd_d    = 1'b1;
        end else begin
          bit_idx_d = bit_idx_q + 4'd1;
          txd_d     = shift_q[0];
          shift_d   = {1'b1, shift_q[8:1]};
        end
      end else begin
        baud_d = baud_q + CW'(1);
      end
    end else begin
      txd_d = 1'b1;
    end
  end

  // Serialiser registers; the line is held high in reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      active_q  <= 1'b0;
      bit_idx_q <= 4'd0;
      baud_q    <= '0;
      shift_q   <= 9'h1FF;
      txd_q     <= 1'b1;
    end else begin
      active_q  <= active_d;
      bit_idx_q <= bit_idx_d;
      baud_q    <= baud_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
    end
  end

endmodule

// File: rtl/uart_mult_byte_tx.sv
// Multi-byte UART packet transmitter: 0x55 0xAA payload[0..len-1] [CHK], 8N1.
// Optional feature macro: UART_TX_CHECKSUM_EN appends a modulo-256 sum of the
// payload bytes after the payload. Without it the frame ends after the payload.
module uart_mult_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned UART_BPS  = 115200,
  parameter int unsigned MAX_BYTES = 12
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   tx_start,
  input  logic [3:0]             tx_len,
  input  logic [8*MAX_BYTES-1:0] tx_payload,
  output logic                   uart_txd,
  output logic                   tx_busy,
  output logic                   tx_done,
  output logic                   tx_err,
  output logic [3:0]             byte_cnt
);

  localparam int unsigned BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
  localparam logic [3:0]  MAX_LEN = 4'(MAX_BYTES);

  frame_state_e           state_q, state_d;
  logic [3:0]             len_q, len_d;
  logic [8*MAX_BYTES-1:0] payload_q, payload_d;
  logic [3:0]             byte_cnt_q, byte_cnt_d;
  logic                   busy_q, done_q, err_q, err_d;
  logic                   byte_start_s, byte_ready_s, legal_s;
  logic [7:0]             byte_data_s;
`ifdef UART_TX_CHECKSUM_EN
  logic [7:0]             chk_q, chk_d;
`endif

  assign legal_s  = (tx_len != 4'd0) && (tx_len <= MAX_LEN);
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign tx_err   = err_q;
  assign byte_cnt = byte_cnt_q;

  uart_byte_tx #(.BPS_CNT(BPS_CNT)) u_byte_tx (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .byte_start (byte_start_s),
    .byte_data  (byte_data_s),
    .txd        (uart_txd),
    .byte_ready (byte_ready_s)
  );

  // Frame sequencer: picks the next byte whenever the serialiser is ready.
  // The payload register shifts down one byte per load, so byte 0 is always [7:0].
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    payload_d    = payload_q;
    byte_cnt_d   = byte_cnt_q;
    err_d        = 1'b0;
    byte_start_s = 1'b0;
    byte_data_s  = 8'h00;
`ifdef UART_TX_CHECKSUM_EN
    chk_d        = chk_q;
`endif
    case (state_q)
      S_IDLE: begin
        byte_cnt_d = 4'd0;
        if (tx_start) begin
          if (legal_s) begin
            state_d      = S_HDR0;
            len_d        = tx_len;
            payload_d    = tx_payload;
            byte_start_s = 1'b1;
            byte_data_s  = HDR0;
`ifdef UART_TX_CHECKSUM_EN
            chk_d        = 8'h00;
`endif
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR0: begin
        if (byte_ready_s) begin
          byte_start_s = 1'b1;
          byte_data_s  = HDR1;
          state_d      = S_HDR1;
        end else begin
          state_d = S_HDR0;
        end
      end
      S_HDR1: begin
        if (byte_ready_s) begin
          byte_start_s = 1'b1;
          byte_data_s  = payload_q[7:0];
          payload_d    = payload_q >> 8;
          byte_cnt_d   = 4'd0;
`ifdef UART_TX_CHECKSUM_EN
          chk_d        = chk_q + payload_q[7:0];
`endif
          state_d      = S_PAY;
        end else begin
          state_d = S_HDR1;
        end
      end
      S_PAY: begin
        if (byte_ready_s) begin
          if (byte_cnt_q == (len_q - 4'd1)) begin
            byte_cnt_d = 4'd0;
`ifdef UART_TX_CHECKSUM_EN
            byte_start_s = 1'b1;
            byte_data_s  = chk_q;
            state_d      = S_CHK;
`else
            state_d      = S_DONE;
`endif
          end else begin
            byte_start_s = 1'b1;
            byte_data_s  = payload_q[7:0];
            payload_d    = payload_q >> 8;
            byte_cnt_d   = byte_cnt_q + 4'd1;
`ifdef UART_TX_CHECKSUM_EN
            chk_d        = chk_q + payload_q[7:0];
`endif
          end
        end else begin
          state_d = S_PAY;
        end
      end
      S_CHK: begin
`ifdef UART_TX_CHECKSUM_EN
        if (byte_ready_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CHK;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, captured request and registered status outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      len_q      <= 4'd0;
      payload_q  <= '0;
      byte_cnt_q <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef UART_TX_CHECKSUM_EN
      chk_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      payload_q  <= payload_d;
      byte_cnt_q <= byte_cnt_d;
      busy_q     <= (state_d == S_HDR0) || (state_d == S_HDR1) ||
                    (state_d == S_PAY)  || (state_d == S_CHK);
      done_q     <= (state_d == S_DONE);
      err_q      <= err_d;
`ifdef UART_TX_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Self-checking bench for uart_mult_byte_tx with a frame-level reference model.
module tb_uart_mult_byte_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int UART_BPS = 115200;
  localparam int MAXB     = 12;
  localparam int B        = CLK_FREQ / UART_BPS;  // 8 cycles per bit
`ifdef UART_TX_CHECKSUM_EN
  localparam int C = 1;
`else
  localparam int C = 0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        tx_start;
  logic [3:0]  tx_len;
  logic [95:0] tx_payload;
  logic        uart_txd, tx_busy, tx_done, tx_err;
  logic [3:0]  byte_cnt;

  uart_mult_byte_tx #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .MAX_BYTES(MAXB)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_start(tx_start), .tx_len(tx_len),
    .tx_payload(tx_payload), .uart_txd(uart_txd), .tx_busy(tx_busy),
    .tx_done(tx_done), .tx_err(tx_err), .byte_cnt(byte_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: frame bytes plus a cycle offset into the frame.
  int          cyc = 0;
  bit          model_valid = 0;
  bit          m_active = 0;
  bit          m_err = 0;
  int          m_off, m_total, m_len, acc_cyc;
  logic [7:0]  m_fb [16];

  always @(posedge sys_clk) begin
    cyc++;
    model_valid = 1;
    m_err = 0;
    if (sys_rst) begin
      m_active = 0;
    end else if (m_active) begin
      if (m_off == m_total) m_active = 0;
      else m_off++;
    end else if (tx_start) begin
      if (tx_len >= 1 && tx_len <= MAXB) begin
        logic [7:0] sum;
        sum = 8'h00;
        m_len = tx_len;
        m_fb[0] = 8'h55;
        m_fb[1] = 8'hAA;
        for (int k = 0; k < m_len; k++) begin
          m_fb[2+k] = tx_payload[8*k +: 8];
          sum = sum + tx_payload[8*k +: 8];
        end
        if (C == 1) m_fb[2+m_len] = sum;
        m_total = (2 + m_len + C) * 10 * B;
        m_off = 0;
        m_active = 1;
        acc_cyc = cyc;
      end else begin
        m_err = 1;
      end
    end
  end

  // Compare process and event counters.
  int done_cnt = 0, err_cnt = 0, done_cyc = 0, max_cnt = 0;
  always @(negedge sys_clk) begin
    if (model_valid) begin
      logic e_txd, e_busy, e_done;
      int   e_cnt, bi, bt;
      e_busy = m_active && (m_off < m_total);
      e_done = m_active && (m_off == m_total);
      e_txd  = 1'b1;
      e_cnt  = 0;
      if (e_busy) begin
        bi = m_off / (10 * B);
        bt = (m_off / B) % 10;
        e_txd = (bt == 0) ? 1'b0 : (bt == 9) ? 1'b1 : m_fb[bi][bt-1];
        if (bi >= 2 && bi < 2 + m_len) e_cnt = bi - 2;
      end
      vectors++;
      if (uart_txd !== e_txd || tx_busy !== e_busy || tx_done !== e_done ||
          tx_err !== m_err || byte_cnt !== 4'(e_cnt)) begin
        miscompares++;
        if (miscompares <= 20)
          $display("FAIL model cyc=%0d txd=%b exp %b busy=%b exp %b done=%b exp %b err=%b exp %b cnt=%0d exp %0d",
                   cyc, uart_txd, e_txd, tx_busy, e_busy, tx_done, e_done, tx_err, m_err, byte_cnt, e_cnt);
      end
    end
    if (tx_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (tx_err === 1'b1) err_cnt++;
    if (byte_cnt > max_cnt) max_cnt = byte_cnt;
  end

  // Line decoder: recovers bytes from uart_txd by mid-bit sampling.
  logic [7:0] rxq[$];
  bit         dbusy = 0;
  int         dt;
  logic [7:0] dsh;
  always @(negedge sys_clk) begin
    if (sys_rst === 1'b1) begin
      dbusy = 0;
    end else if (!dbusy) begin
      if (uart_txd === 1'b0) begin dbusy = 1; dt = 0; end
    end else begin
      dt++;
      if (dt % B == B / 2) begin
        if (dt / B >= 1 && dt / B <= 8) dsh[dt/B - 1] = uart_txd;
        if (dt / B == 9) begin rxq.push_back(dsh); dbusy = 0; end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_bytes(input string name, input logic [7:0] exp[$]);
    check({name, "_count"}, rxq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rxq.size(); i++)
      check($sformatf("%s_byte%0d", name, i), rxq[i], exp[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [3:0] len, input logic [95:0] pay);
    @(negedge sys_clk); #1;
    tx_start = 1'b1; tx_len = len; tx_payload = pay;
    @(negedge sys_clk); #1;
    tx_start = 1'b0;
    tx_len = 4'($urandom);
    tx_payload = {$urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(input int limit);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < limit) begin @(negedge sys_clk); n++; end
    if (done_cnt == d0) check("done_timeout", 0, 1);
    idle(2);
  endtask

  initial begin
    logic [7:0] exp[$];
    int d0, e0, n;
    sys_rst = 1'b1; tx_start = 1'b0; tx_len = 4'd0; tx_payload = '0;
    idle(3);
    check("reset_txd", uart_txd, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_cnt", byte_cnt, 0);
    sys_rst = 1'b0;
    idle(2);

    // Basic frame 01 02 03
    rxq.delete();
    send(4'd3, 96'h030201);
    wait_done(3000);
`ifdef UART_TX_CHECKSUM_EN
    check("basic_duration", done_cyc - acc_cyc, 480);
    exp = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h06};
`else
    check("basic_duration", done_cyc - acc_cyc, 400);
    exp = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h03};
`endif
    check_bytes("basic", exp);

    // Illegal lengths
    e0 = err_cnt; rxq.delete();
    send(4'd0, 96'h1);
    idle(3);
    send(4'd13, 96'h1);
    idle(3);
    check("illegal_errs", err_cnt - e0, 2);
    check("illegal_busy", tx_busy, 0);
    check("illegal_txd", uart_txd, 1);
    check("illegal_nobytes", rxq.size(), 0);

    // Request while busy
    d0 = done_cnt; rxq.delete();
    send(4'd2, 96'hBEEF);
    idle(100);
    send(4'd5, 96'h1122334455);
    wait_done(3000);
    idle(200);
    check("busy_single_done", done_cnt - d0, 1);
    exp = '{8'h55, 8'hAA, 8'hEF, 8'hBE};
`ifdef UART_TX_CHECKSUM_EN
    exp.push_back(8'hAD);
`endif
    check_bytes("busy", exp);

    // Checksum wrap, 12 x FF
    rxq.delete(); max_cnt = 0;
    send(4'd12, {96{1'b1}});
    wait_done(3000);
    check("wrap_max_cnt", max_cnt, 11);
    exp = '{8'h55, 8'hAA, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
            8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`ifdef UART_TX_CHECKSUM_EN
    exp.push_back(8'hF4);
`endif
    check_bytes("wrap", exp);

    // Reset during payload byte 1
    d0 = done_cnt;
    send(4'd4, 96'h44332211);
    n = 0;
    while (byte_cnt !== 4'd1 && n < 1000) begin @(negedge sys_clk); n++; end
    check("rst_reach_byte1", byte_cnt, 1);
    idle(3);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("midrst_txd", uart_txd, 1);
    check("midrst_busy", tx_busy, 0);
    check("midrst_cnt", byte_cnt, 0);
    #1 sys_rst = 1'b0;
    idle(100);
    check("midrst_no_done", done_cnt - d0, 0);
    rxq.delete();
    send(4'd1, 96'h5A);
    wait_done(3000);
    exp = '{8'h55, 8'hAA, 8'h5A};
`ifdef UART_TX_CHECKSUM_EN
    exp.push_back(8'h5A);
`endif
    check_bytes("after_rst", exp);

    // Randomised frames, some with a request injected mid-frame
    for (int it = 0; it < 12; it++) begin
      logic [3:0] l;
      l = 4'($urandom_range(0, 15));
      send(l, {$urandom, $urandom, $urandom});
      if (l >= 1 && l <= MAXB) begin
        if ($urandom_range(0, 1) == 1) begin
          idle($urandom_range(1, 150));
          send(4'($urandom_range(1, 12)), {$urandom, $urandom, $urandom});
        end
        wait_done(3000);
        idle($urandom_range(0, 3));
      end else begin
        idle(3);
      end
    end
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
